// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction prefetch path.
// Covers the opcode width, the fetch FSM encoding and the instruction-length rule.
package fetch_pkg;

  localparam int unsigned OPCODE_W = 16;

  typedef enum logic [1:0] {
    FLUSH,
    RUN,
    STALL
  } fetch_state_t;

  // Total bytes occupied by an instruction whose opcode is already known.
  function automatic int unsigned instr_len(
    input logic [OPCODE_W-1:0] opcode,
    input int unsigned         imm_flag_bit,
    input int unsigned         imm_bytes
  );
    logic [OPCODE_W-1:0] shifted;
    shifted = opcode >> imm_flag_bit;
    return shifted[0] ? 2 + imm_bytes : 2;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Circular byte FIFO with multi-byte push, variable-length pop and a head window.
// The head window always shows WIN bytes starting at the read pointer; bytes past count are stale.
module byte_fifo #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned PUSH_W = 1,
  parameter int unsigned WIN    = 6,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [8*PUSH_W-1:0] push_data,
  input  logic [CW-1:0]     push_cnt,
  input  logic [CW-1:0]     pop_cnt,
  output logic [8*WIN-1:0]  window,
  output logic [CW-1:0]     count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      for (int unsigned i = 0; i < PUSH_W; i++) begin
        if (CW'(i) < push_cnt) begin
          mem[wr_ptr + PW'(i)] <= push_data[8*i +: 8];
        end
      end
      wr_ptr <= wr_ptr + PW'(push_cnt);
      rd_ptr <= rd_ptr + PW'(pop_cnt);
      count  <= count + push_cnt - pop_cnt;
    end
  end

  always_comb begin
    window = '0;
    for (int unsigned i = 0; i < WIN; i++) begin
      window[8*i +: 8] = mem[rd_ptr + PW'(i)];
    end
  end

endmodule

// File: rtl/prefetch_unit.sv
// Instruction prefetcher: streams bytes from a synchronous-read memory into a byte FIFO
// and presents opcode + optional little-endian immediate on a valid/ready interface.
module prefetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned BUS_BYTES    = 1,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned IMM_BYTES    = 4,
  parameter int unsigned IMM_FLAG_BIT = 15,
  parameter int unsigned RESET_PC     = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [ADDR_W-1:0]      m_addr,
  output logic                   m_req,
  input  logic [8*BUS_BYTES-1:0] m_data,
  input  logic                   redirect,
  input  logic [ADDR_W-1:0]      redirect_pc,
  output logic                   ins_valid,
  input  logic                   ins_ready,
  output logic [OPCODE_W-1:0]    ins,
  output logic [8*IMM_BYTES-1:0] imm,
  output logic [ADDR_W-1:0]      ins_pc
);

  localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned WIN = 2 + IMM_BYTES;
  localparam int unsigned DW  = (BUS_BYTES > 1) ? $clog2(BUS_BYTES) : 1;

  localparam logic [ADDR_W-1:0] ALIGN_MASK    = ~ADDR_W'(BUS_BYTES - 1);
  localparam logic [ADDR_W-1:0] RESET_PC_A    = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] RESET_ALIGNED = RESET_PC_A & ALIGN_MASK;
  localparam logic [DW-1:0]     RESET_DROP    = DW'(RESET_PC_A & ~ALIGN_MASK);

  if (FIFO_DEPTH < 2 + IMM_BYTES + BUS_BYTES) begin : g_depth_chk
    $error("prefetch_unit: FIFO_DEPTH must be >= 2 + IMM_BYTES + BUS_BYTES");
  end
  if ((BUS_BYTES & (BUS_BYTES - 1)) != 0 || BUS_BYTES > 4) begin : g_bus_chk
    $error("prefetch_unit: BUS_BYTES must be 1, 2 or 4");
  end

  fetch_state_t state;
  fetch_state_t state_nxt;

  logic [ADDR_W-1:0]      fetch_addr;
  logic [ADDR_W-1:0]      pc;
  logic [DW-1:0]          drop_cnt;
  logic                   inflight;
  logic                   credit_ok;
  logic                   req;
  logic                   rsp;
  logic                   fire;
  logic                   has_imm;
  logic [CW-1:0]          count;
  logic [CW-1:0]          push_cnt;
  logic [CW-1:0]          pop_cnt;
  logic [CW-1:0]          needed;
  logic [8*BUS_BYTES-1:0] push_data;
  logic [8*WIN-1:0]       window;
  logic [OPCODE_W-1:0]    opcode;

  // Reserve room for the response already on the bus plus the one a new request would bring,
  // so the FIFO cannot overflow even if nothing is popped.
  assign credit_ok = (32'(count) + (inflight ? BUS_BYTES : 32'd0) + BUS_BYTES) <= FIFO_DEPTH;

  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    unique case (state)
      FLUSH: state_nxt = RUN;
      RUN: begin
        if (credit_ok) begin
          req = 1'b1;
        end else begin
          state_nxt = STALL;
        end
      end
      STALL: begin
        if (credit_ok) begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = FLUSH;
    endcase
  end

  assign m_req  = req && !rst && !redirect;
  assign m_addr = rst ? RESET_ALIGNED : fetch_addr;

  // Clearing the in-flight flag on redirect/reset plays the role of an epoch bit:
  // a stale response lands while the flag is low and is ignored.
  assign rsp       = inflight && (state != FLUSH);
  assign push_cnt  = rsp ? CW'(BUS_BYTES - 32'(drop_cnt)) : '0;
  assign push_data = m_data >> {drop_cnt, 3'b000};

  assign opcode    = window[OPCODE_W-1:0];
  assign has_imm   = opcode[IMM_FLAG_BIT];
  assign needed    = CW'(instr_len(opcode, IMM_FLAG_BIT, IMM_BYTES));
  assign ins_valid = !rst && !redirect && (count >= CW'(2)) && (count >= needed);
  assign fire      = ins_valid && ins_ready;
  assign pop_cnt   = fire ? needed : '0;

  assign ins    = rst ? '0 : opcode;
  assign imm    = (rst || !has_imm) ? '0 : window[8*WIN-1:16];
  assign ins_pc = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FLUSH;
      fetch_addr <= RESET_ALIGNED;
      drop_cnt   <= RESET_DROP;
      pc         <= RESET_PC_A;
      inflight   <= 1'b0;
    end else if (redirect) begin
      state      <= FLUSH;
      fetch_addr <= redirect_pc & ALIGN_MASK;
      drop_cnt   <= DW'(redirect_pc & ~ALIGN_MASK);
      pc         <= redirect_pc;
      inflight   <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= m_req;
      if (m_req) begin
        fetch_addr <= fetch_addr + ADDR_W'(BUS_BYTES);
      end
      if (rsp) begin
        drop_cnt <= '0;
      end
      if (fire) begin
        pc <= pc + ADDR_W'(needed);
      end
    end
  end

  byte_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .PUSH_W (BUS_BYTES),
    .WIN    (WIN)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect),
    .push_data (push_data),
    .push_cnt  (push_cnt),
    .pop_cnt   (pop_cnt),
    .window    (window),
    .count     (count)
  );

endmodule
